// File: rtl/ci_fft_sequencer.sv
// Frame sequencer between ADC capture and a 16-point FFT core: buffers samples,
// paces new-data strobes, and indexes the output bins into frames.
module ci_fft_sequencer #(
    parameter int ADC_W      = 12,
    parameter int NPTS       = 16,
    parameter int NPTS_LOG2  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int OFFSET_BIN = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 err_clr,
    input  logic                 adc_valid,
    input  logic [ADC_W-1:0]     adc_data,
    output logic                 fft_nd,
    output logic [2*ADC_W-1:0]   fft_x,
    input  logic                 fft_out_nd,
    input  logic [2*ADC_W-1:0]   fft_out_x,
    input  logic                 fft_overflow,
    output logic                 bin_valid,
    output logic [NPTS_LOG2-1:0] bin_idx,
    output logic [ADC_W-1:0]     bin_re,
    output logic [ADC_W-1:0]     bin_im,
    output logic                 frame_done,
    output logic [7:0]           frame_cnt,
    output logic                 busy,
    output logic                 err_drop,
    output logic                 err_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]          FIFO_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [NPTS_LOG2-1:0] LAST_IDX  = NPTS_LOG2'(NPTS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FEED = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [ADC_W-1:0]     fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [AW:0]          count_r;
    logic                 empty_s;
    logic                 full_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 drop_s;
    logic                 gap_r;
    logic [NPTS_LOG2-1:0] feed_cnt_r;
    logic [NPTS_LOG2-1:0] bin_cnt_r;

    // Offset-binary to two's complement: flipping the MSB recentres the range on zero.
    function automatic logic [ADC_W-1:0] conv_sample(input logic [ADC_W-1:0] s);
        logic [ADC_W-1:0] r;
        if (OFFSET_BIN != 0) begin
            r = {~s[ADC_W-1], s[ADC_W-2:0]};
        end else begin
            r = s;
        end
        return r;
    endfunction

    assign empty_s = (count_r == '0);
    assign full_s  = (count_r == FIFO_FULL);

    // Pop/push/drop decisions; a pop in the same cycle frees a slot for a full FIFO.
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        drop_s = 1'b0;
        if ((state_r == ST_FEED) && !empty_s && !gap_r) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (adc_valid && (!full_s || pop_s)) begin
            push_s = 1'b1;
        end else if (adc_valid) begin
            drop_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Next state: a stop request only takes effect on the last pop of a frame.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_next_s = ST_FEED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (pop_s && (feed_cnt_r == LAST_IDX) && !enable) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_FEED;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and busy flag, registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy    <= (state_next_s == ST_FEED);
        end
    end

    // Sample FIFO storage and pointers; no bypass path from push to pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= adc_data;
                wr_ptr_r             <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Core feed: the gap flag blocks the pop right after a strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fft_nd     <= 1'b0;
            fft_x      <= '0;
            gap_r      <= 1'b0;
            feed_cnt_r <= '0;
        end else begin
            fft_nd <= pop_s;
            gap_r  <= pop_s;
            if (pop_s) begin
                fft_x      <= {conv_sample(fifo_mem_r[rd_ptr_r]), {ADC_W{1'b0}}};
                feed_cnt_r <= feed_cnt_r + NPTS_LOG2'(1);
            end
        end
    end

    // Output bin indexing and frame counting, independent of the feed state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_valid  <= 1'b0;
            bin_idx    <= '0;
            bin_re     <= '0;
            bin_im     <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
            bin_cnt_r  <= '0;
        end else begin
            bin_valid  <= fft_out_nd;
            frame_done <= fft_out_nd && (bin_cnt_r == LAST_IDX);
            if (fft_out_nd) begin
                bin_re    <= fft_out_x[2*ADC_W-1:ADC_W];
                bin_im    <= fft_out_x[ADC_W-1:0];
                bin_idx   <= bin_cnt_r;
                bin_cnt_r <= bin_cnt_r + NPTS_LOG2'(1);
                if (bin_cnt_r == LAST_IDX) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    // Sticky error flags; a new event outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_drop <= 1'b0;
            err_ovf  <= 1'b0;
        end else begin
            if (drop_s) begin
                err_drop <= 1'b1;
            end else if (err_clr) begin
                err_drop <= 1'b0;
            end
            if (fft_overflow) begin
                err_ovf <= 1'b1;
            end else if (err_clr) begin
                err_ovf <= 1'b0;
            end
        end
    end

endmodule
